demux1to4_dispatcher: RTL and testbench



---
 rtl/demux_disp_pkg.sv | 21 ++
 rtl/rr_pick4.sv | 23 ++
 rtl/demux1to4_dispatcher.sv | 111 +++++++++++
 tb/tb_demux1to4_dispatcher.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/demux_disp_pkg.sv
// Shared types and sizing for the 1-to-4 round-robin dispatcher.
// Channel count is fixed at four, so the select is two bits wide.
package demux_disp_pkg;

  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARB  = 2'd1,
    SEND = 2'd2
  } state_e;

  function automatic logic [NUM_CH-1:0] ch_onehot(input logic [SEL_W-1:0] idx);
    logic [NUM_CH-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational 4-way round-robin pick: first set request after last_i, wrapping.
// Pure logic, no state; any_o flags that at least one request is set.
module rr_pick4 (
  input  logic [3:0] req_i,
  input  logic [1:0] last_i,
  output logic [1:0] pick_o,
  output logic       any_o
);

  logic [1:0] idx;

  always_comb begin
    pick_o = last_i;
    idx    = '0;
    // Walk from the farthest offset down so the nearest candidate wins.
    for (int i = 4; i >= 1; i--) begin
      idx = last_i + 2'(i);
      if (req_i[idx]) pick_o = idx;
    end
    any_o = |req_i;
  end

endmodule

// File: rtl/demux1to4_dispatcher.sv
// Round-robin dispatcher: buffers one producer word and delivers it to one of four channels.
// Accept-to-valid latency two cycles; in_ready only when idle or when the current word is taken.
module demux1to4_dispatcher #(
  parameter int WIDTH  = 8,
  parameter int NUM_CH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_data,
  input  logic [NUM_CH-1:0] ch_en,
  output logic [NUM_CH-1:0] out_valid,
  input  logic [NUM_CH-1:0] out_ready,
  output logic [WIDTH-1:0]  out_data,
  output logic [1:0]        sel,
  output logic              stall
);

  import demux_disp_pkg::state_e;
  import demux_disp_pkg::IDLE;
  import demux_disp_pkg::ARB;
  import demux_disp_pkg::SEND;
  import demux_disp_pkg::SEL_W;
  import demux_disp_pkg::ch_onehot;

  state_e             state_q, state_d;
  logic [SEL_W-1:0]   ptr_q, ptr_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic [NUM_CH-1:0]  ovld_q, ovld_d;

  logic [SEL_W-1:0]   pick;
  logic               any_req;
  logic               accept;

  rr_pick4 u_pick (
    .req_i  (ch_en),
    .last_i (ptr_q),
    .pick_o (pick),
    .any_o  (any_req)
  );

  // A word only completes while its channel is still enabled.
  assign accept   = (state_q == SEND) & out_ready[sel_q] & ch_en[sel_q];
  assign in_ready = rst_n & ((state_q == IDLE) | accept);

  assign out_valid = ovld_q;
  assign out_data  = data_q;
  assign sel       = sel_q;
  assign stall     = (state_q == ARB) & ~any_req;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    data_d  = data_q;
    ovld_d  = ovld_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          data_d  = in_data;
          state_d = ARB;
        end
      end
      ARB: begin
        if (any_req) begin
          sel_d   = pick;
          ovld_d  = ch_onehot(pick);
          state_d = SEND;
        end
      end
      SEND: begin
        if (!ch_en[sel_q]) begin
          ovld_d  = '0;
          state_d = ARB;
        end else if (out_ready[sel_q]) begin
          ptr_d  = sel_q;
          ovld_d = '0;
          if (in_valid) begin
            data_d  = in_data;
            state_d = ARB;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        ovld_d  = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= 2'd3;
      sel_q   <= '0;
      data_q  <= '0;
      ovld_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      data_q  <= data_d;
      ovld_q  <= ovld_d;
    end
  end

endmodule

// File: tb/tb_demux1to4_dispatcher.sv
// Directed bench for demux1to4_dispatcher: each scenario task drives vectors and checks inline.
module tb_demux1to4_dispatcher;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic [3:0] ch_en;
  logic [3:0] out_valid;
  logic [3:0] out_ready;
  logic [7:0] out_data;
  logic [1:0] sel;
  logic       stall;

  int errors = 0;
  int checks = 0;

  demux1to4_dispatcher #(.WIDTH(8), .NUM_CH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .ch_en     (ch_en),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .sel       (sel),
    .stall     (stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; ch_en = 4'b0000; out_ready = 4'b0000;
    tick(); tick();
    checks++; if (out_valid !== 4'b0000) begin errors++; $display("FAIL reset_out_valid got=%b exp=0000", out_valid); end
    checks++; if (sel !== 2'd0) begin errors++; $display("FAIL reset_sel got=%0d exp=0", sel); end
    checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data got=%h exp=00", out_data); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b exp=0", stall); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
    rst_n = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL idle_in_ready got=%b exp=1", in_ready); end
  endtask

  // Full throughput stream A0..A3, all channels enabled and ready.
  task automatic test_stream();
    logic [7:0] exp_d;
    logic [3:0] exp_v;
    ch_en = 4'b1111; out_ready = 4'b1111;
    in_valid = 1'b1; in_data = 8'hA0;
    tick();
    checks++; if (out_valid !== 4'b0000 || in_ready !== 1'b0) begin errors++; $display("FAIL stream_arb got v=%b rdy=%b exp v=0000 rdy=0", out_valid, in_ready); end
    for (int k = 0; k < 4; k++) begin
      if (k == 3) in_valid = 1'b0; else in_data = 8'hA1 + 8'(k);
      tick();
      exp_d = 8'hA0 + 8'(k);
      exp_v = 4'b0001 << k;
      checks++; if (out_valid !== exp_v || sel !== 2'(k) || out_data !== exp_d) begin
        errors++; $display("FAIL stream_send%0d got v=%b sel=%0d d=%h exp v=%b sel=%0d d=%h", k, out_valid, sel, out_data, exp_v, k, exp_d);
      end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_in_ready%0d got=%b exp=1", k, in_ready); end
      tick();
      checks++; if (out_valid !== 4'b0000) begin errors++; $display("FAIL stream_gap%0d got=%b exp=0000", k, out_valid); end
    end
  endtask

  // Channels 0 and 2 only: expect 0,2,0,2,0,2.
  task automatic test_mask();
    logic [3:0] exp_v;
    logic [1:0] exp_s;
    ch_en = 4'b0101; out_ready = 4'b1111;
    in_valid = 1'b1; in_data = 8'hB0;
    tick();
    for (int k = 0; k < 6; k++) begin
      if (k == 5) in_valid = 1'b0; else in_data = 8'hB1 + 8'(k);
      tick();
      exp_s = (k % 2 == 0) ? 2'd0 : 2'd2;
      exp_v = (k % 2 == 0) ? 4'b0001 : 4'b0100;
      checks++; if (out_valid !== exp_v || sel !== exp_s || out_data !== (8'hB0 + 8'(k))) begin
        errors++; $display("FAIL mask_send%0d got v=%b sel=%0d d=%h exp v=%b sel=%0d d=%h", k, out_valid, sel, out_data, exp_v, exp_s, 8'hB0 + 8'(k));
      end
      tick();
    end
  endtask

  task automatic test_stall();
    ch_en = 4'b0000; out_ready = 4'b1111;
    in_valid = 1'b1; in_data = 8'h5A;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      checks++; if (stall !== 1'b1 || in_ready !== 1'b0 || out_valid !== 4'b0000 || out_data !== 8'h5A) begin
        errors++; $display("FAIL stall_hold%0d got st=%b rdy=%b v=%b d=%h exp st=1 rdy=0 v=0000 d=5a", k, stall, in_ready, out_valid, out_data);
      end
      tick();
    end
    ch_en = 4'b1000;
    tick();
    checks++; if (stall !== 1'b0 || sel !== 2'd3 || out_valid !== 4'b1000 || out_data !== 8'h5A) begin
      errors++; $display("FAIL stall_release got st=%b sel=%0d v=%b d=%h exp st=0 sel=3 v=1000 d=5a", stall, sel, out_valid, out_data);
    end
    tick();
    checks++; if (out_valid !== 4'b0000 || in_ready !== 1'b1) begin errors++; $display("FAIL stall_done got v=%b rdy=%b exp v=0000 rdy=1", out_valid, in_ready); end
  endtask

  // ch1 held unready, then disabled: word must re-route to ch2.
  task automatic test_drop();
    ch_en = 4'b0010; out_ready = 4'b0000;
    in_valid = 1'b1; in_data = 8'h3C;
    tick();
    in_valid = 1'b0;
    tick();
    ch_en = 4'b0110;
    for (int k = 0; k < 5; k++) begin
      checks++; if (out_valid !== 4'b0010 || sel !== 2'd1 || out_data !== 8'h3C) begin
        errors++; $display("FAIL drop_wait%0d got v=%b sel=%0d d=%h exp v=0010 sel=1 d=3c", k, out_valid, sel, out_data);
      end
      tick();
    end
    ch_en = 4'b0100;
    tick();
    checks++; if (out_valid !== 4'b0000 || out_data !== 8'h3C) begin errors++; $display("FAIL drop_clear got v=%b d=%h exp v=0000 d=3c", out_valid, out_data); end
    tick();
    checks++; if (out_valid !== 4'b0100 || sel !== 2'd2 || out_data !== 8'h3C) begin
      errors++; $display("FAIL drop_rearb got v=%b sel=%0d d=%h exp v=0100 sel=2 d=3c", out_valid, sel, out_data);
    end
    out_ready = 4'b1111;
    tick();
    checks++; if (out_valid !== 4'b0000) begin errors++; $display("FAIL drop_accept got v=%b exp=0000", out_valid); end
  endtask

  // Non-selected out_ready must be ignored; accept on ch0 moves ptr to 0.
  task automatic test_hold();
    ch_en = 4'b0001; out_ready = 4'b1110;
    in_valid = 1'b1; in_data = 8'h77;
    tick();
    in_valid = 1'b0;
    tick();
    for (int k = 0; k < 3; k++) begin
      checks++; if (out_valid !== 4'b0001 || sel !== 2'd0 || out_data !== 8'h77) begin
        errors++; $display("FAIL hold_stable%0d got v=%b sel=%0d d=%h exp v=0001 sel=0 d=77", k, out_valid, sel, out_data);
      end
      tick();
    end
    out_ready = 4'b1111;
    tick();
    checks++; if (out_valid !== 4'b0000) begin errors++; $display("FAIL hold_accept got v=%b exp=0000", out_valid); end
    ch_en = 4'b1111;
    in_valid = 1'b1; in_data = 8'h78;
    tick();
    in_valid = 1'b0;
    tick();
    checks++; if (sel !== 2'd1 || out_valid !== 4'b0010 || out_data !== 8'h78) begin
      errors++; $display("FAIL hold_ptr got sel=%0d v=%b d=%h exp sel=1 v=0010 d=78", sel, out_valid, out_data);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    ch_en = 4'b1111; out_ready = 4'b0000;
    in_valid = 1'b1; in_data = 8'hFF;
    tick();
    in_valid = 1'b0;
    tick();
    checks++; if (out_valid !== 4'b0100 || sel !== 2'd2 || out_data !== 8'hFF) begin
      errors++; $display("FAIL rstmid_send got v=%b sel=%0d d=%h exp v=0100 sel=2 d=ff", out_valid, sel, out_data);
    end
    rst_n = 1'b0;
    tick();
    checks++; if (out_valid !== 4'b0000 || sel !== 2'd0 || in_ready !== 1'b0 || out_data !== 8'h00) begin
      errors++; $display("FAIL rstmid_reset got v=%b sel=%0d rdy=%b d=%h exp v=0000 sel=0 rdy=0 d=00", out_valid, sel, in_ready, out_data);
    end
    out_ready = 4'b1111;
    tick();
    checks++; if (out_valid !== 4'b0000 || in_ready !== 1'b0) begin errors++; $display("FAIL rstmid_held got v=%b rdy=%b exp v=0000 rdy=0", out_valid, in_ready); end
    rst_n = 1'b1;
    tick();
    checks++; if (out_valid !== 4'b0000 || in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_release got v=%b rdy=%b exp v=0000 rdy=1", out_valid, in_ready); end
    in_valid = 1'b1; in_data = 8'h11;
    tick();
    in_valid = 1'b0;
    tick();
    checks++; if (out_valid !== 4'b0001 || sel !== 2'd0 || out_data !== 8'h11) begin
      errors++; $display("FAIL rstmid_first got v=%b sel=%0d d=%h exp v=0001 sel=0 d=11", out_valid, sel, out_data);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_stream();
    test_mask();
    test_stall();
    test_drop();
    test_hold();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
